// File: rtl/result_drain_buffer.sv
// result_drain_buffer: captures row-wide result vectors drained by the
// systolic array, accumulates per-tile partial sums in a result RAM through
// a 2-stage read-modify-write pipeline, and streams the finished matrix out
// one lane per cycle on request.
module result_drain_buffer #(
  parameter int OUT_WIDTH  = 32,
  parameter int ROW_A      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         deload_out,
  input  logic                         acc_first,
  input  logic [ADDR_WIDTH-1:0]        addr_res,
  input  logic [OUT_WIDTH*ROW_A-1:0]   out,
  input  logic                         test_en,
  output logic [DATA_WIDTH-1:0]        test_data,
  output logic                         test_valid,
  output logic                         test_done,
  output logic                         busy,
  output logic                         drop_err
);

  localparam int ROW_W  = OUT_WIDTH * ROW_A;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANE_W = (ROW_A > 1) ? $clog2(ROW_A) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ROW_W-1:0]        ram_q [DEPTH];

  // Write-pipeline stage 2 contents (captured by stage 1 at the accept edge)
  logic                    wr_valid_q;
  logic                    wr_first_q;
  logic [IDX_W-1:0]        wr_addr_q;
  logic [ROW_W-1:0]        wr_in_q;
  logic [ROW_W-1:0]        wr_old_q;
  logic [ROW_W-1:0]        wr_new_d;

  // Readout state and registered outputs
  logic [IDX_W-1:0]        rd_row_q;
  logic [LANE_W-1:0]       rd_lane_q;
  logic [OUT_WIDTH-1:0]    rd_lane_d;
  logic                    rd_last_d;
  logic [DATA_WIDTH-1:0]   test_data_q;
  logic                    test_valid_q;
  logic                    test_done_q;
  logic                    drop_err_q;

  logic                    in_range_d;
  logic                    accept_d;
  logic                    drop_d;
  logic [IDX_W-1:0]        addr_idx_d;
  logic [ROW_W-1:0]        ram_rd_d;

  assign in_range_d = ({1'b0, addr_res} < DEPTH_A);
  assign accept_d   = deload_out && in_range_d && (state_q == ST_IDLE);
  assign drop_d     = deload_out && !accept_d;
  assign addr_idx_d = addr_res[IDX_W-1:0];

  // Stage-1 row read; the row being committed this edge is forwarded so
  // back-to-back accumulates to the same row see the freshest value.
  assign ram_rd_d = (wr_valid_q && (wr_addr_q == addr_idx_d)) ? wr_new_d
                                                              : ram_q[addr_idx_d];

  // Lane-wise merge: overwrite on the first k-tile, otherwise wrapping add
  always_comb begin
    wr_new_d = '0;
    for (int l = 0; l < ROW_A; l++) begin
      if (wr_first_q) begin
        wr_new_d[l*OUT_WIDTH +: OUT_WIDTH] = wr_in_q[l*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        wr_new_d[l*OUT_WIDTH +: OUT_WIDTH] = wr_old_q[l*OUT_WIDTH +: OUT_WIDTH]
                                           + wr_in_q[l*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Stage 1: capture an accepted write together with the current row
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
    end else begin
      wr_valid_q <= accept_d;
      if (accept_d) begin
        wr_addr_q  <= addr_idx_d;
        wr_in_q    <= out;
        wr_first_q <= acc_first;
        wr_old_q   <= ram_rd_d;
      end
    end
  end

  // Stage 2: commit the merged row; a reset in this cycle cancels the commit
  always_ff @(posedge clk) begin
    if (!reset && wr_valid_q) begin
      ram_q[wr_addr_q] <= wr_new_d;
    end
  end

  // Select the lane addressed by the readout counter
  always_comb begin
    rd_lane_d = '0;
    for (int l = 0; l < ROW_A; l++) begin
      if (rd_lane_q == LANE_W'(l)) begin
        rd_lane_d = ram_q[rd_row_q][l*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        rd_lane_d = rd_lane_d;
      end
    end
  end

  assign rd_last_d = (rd_row_q == IDX_W'(DEPTH-1)) && (rd_lane_q == LANE_W'(ROW_A-1));

  // Readout FSM with row-major lane counter and registered stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_row_q     <= '0;
      rd_lane_q    <= '0;
      test_data_q  <= '0;
      test_valid_q <= 1'b0;
      test_done_q  <= 1'b0;
    end else begin
      test_valid_q <= 1'b0;
      test_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (test_en && !wr_valid_q && !accept_d) begin
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (!test_en) begin
            state_q   <= ST_IDLE;
            rd_row_q  <= '0;
            rd_lane_q <= '0;
          end else begin
            test_data_q  <= rd_lane_d[DATA_WIDTH-1:0];
            test_valid_q <= 1'b1;
            test_done_q  <= rd_last_d;
            if (rd_last_d) begin
              state_q   <= ST_DONE;
              rd_row_q  <= '0;
              rd_lane_q <= '0;
            end else if (rd_lane_q == LANE_W'(ROW_A-1)) begin
              rd_lane_q <= '0;
              rd_row_q  <= rd_row_q + IDX_W'(1);
            end else begin
              rd_lane_q <= rd_lane_q + LANE_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (!test_en) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_err_q <= 1'b0;
    end else if (drop_d) begin
      drop_err_q <= 1'b1;
    end
  end

  assign test_data  = test_data_q;
  assign test_valid = test_valid_q;
  assign test_done  = test_done_q;
  assign drop_err   = drop_err_q;
  assign busy       = wr_valid_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_result_drain_buffer.sv
// Scoreboard bench for result_drain_buffer: a lane-array model of the result
// matrix produces expected readout streams, a monitor compares DUT lanes.
module tb_result_drain_buffer;
  localparam int OW  = 32;
  localparam int RA  = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int NL  = DEP * RA;

  logic              clk = 1'b0;
  logic              reset;
  logic              deload_out;
  logic              acc_first;
  logic [AW-1:0]     addr_res;
  logic [OW*RA-1:0]  out_v;
  logic              test_en;
  logic [DW-1:0]     test_data;
  logic              test_valid;
  logic              test_done;
  logic              busy;
  logic              drop_err;

  always #5 clk = ~clk;

  result_drain_buffer #(
    .OUT_WIDTH(OW), .ROW_A(RA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .deload_out(deload_out), .acc_first(acc_first),
    .addr_res(addr_res), .out(out_v), .test_en(test_en), .test_data(test_data),
    .test_valid(test_valid), .test_done(test_done), .busy(busy), .drop_err(drop_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          popped = 0;
  logic [OW-1:0] model [DEP][RA];
  exp_t        exp_q[$];
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid lane is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (test_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_lane: got data 0x%0h with no lane expected", test_data);
      end else begin
        mon_e = exp_q.pop_front();
        popped++;
        check("lane_data", test_data, mon_e.data);
        check("lane_done", test_done, mon_e.last);
      end
    end
  end

  function automatic logic [OW*RA-1:0] splat(input logic [OW-1:0] v);
    return {RA{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write; model follows the overwrite/accumulate rules unless dropped
  task automatic wr(input int addr, input bit first, input logic [OW*RA-1:0] vec, input bit in_read);
    deload_out = 1'b1;
    acc_first  = first;
    addr_res   = AW'(addr);
    out_v      = vec;
    if (addr < DEP && !in_read) begin
      for (int l = 0; l < RA; l++) begin
        if (first) model[addr][l] = vec[l*OW +: OW];
        else       model[addr][l] = model[addr][l] + vec[l*OW +: OW];
      end
    end
    tick();
    deload_out = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < DEP; r++) begin
      for (int l = 0; l < RA; l++) begin
        e.data = model[r][l][DW-1:0];
        e.last = (r == DEP-1) && (l == RA-1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic finish_read(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < NL + 40 && !seen; i++) begin
      @(negedge clk);
      if (test_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    test_en = 1'b0;
    @(negedge clk);
    check({tag, "_valid_after_done"}, test_valid, 0);
    @(negedge clk);
    check({tag, "_all_lanes_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic read_all(input string tag);
    repeat (2) tick();
    push_expected();
    test_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_lat_edgeE"}, test_valid, 0);
    @(negedge clk);
    check({tag, "_lat_edgeE1"}, test_valid, 1);
    finish_read(tag);
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW*RA-1:0] vec;
    int               cnt;
    int               a;

    reset = 1'b1; deload_out = 1'b0; acc_first = 1'b0; addr_res = '0;
    out_v = '0; test_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_test_data", test_data, 0);
    check("rst_test_valid", test_valid, 0);
    check("rst_test_done", test_done, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_err", drop_err, 0);
    reset = 1'b0;
    tick();

    // Overwrite all rows with row*4+lane
    for (int r = 0; r < DEP; r++) begin
      for (int l = 0; l < RA; l++) vec[l*OW +: OW] = OW'(r*RA + l);
      wr(r, 1'b1, vec, 1'b0);
    end
    @(negedge clk);
    check("busy_after_write", busy, 1);
    @(negedge clk);
    check("busy_after_commit", busy, 0);
    read_all("overwrite");

    // Abort after 10 lanes, then restart from lane 0
    repeat (2) tick();
    push_expected();
    popped  = 0;
    cnt     = 0;
    test_en = 1'b1;
    for (int i = 0; i < 40 && cnt < 10; i++) begin
      @(negedge clk);
      if (test_valid) cnt++;
    end
    test_en = 1'b0;
    @(negedge clk);
    check("abort_valid_drop", test_valid, 0);
    check("abort_no_done", test_done, 0);
    check("abort_lane_count", popped, 10);
    exp_q.delete();
    repeat (3) @(negedge clk);
    read_all("restart");

    // Back-to-back accumulate on row 3 with wrap
    wr(3, 1'b1, splat(32'h0000_0005), 1'b0);
    wr(3, 1'b0, splat(32'h0000_0007), 1'b0);
    wr(3, 1'b0, splat(32'hFFFF_FFFF), 1'b0);
    read_all("accumulate");

    // Out-of-range write is dropped
    repeat (2) tick();
    @(negedge clk);
    check("drop_err_clear", drop_err, 0);
    wr(16, 1'b1, splat(32'hBAD0_BAD0), 1'b0);
    @(negedge clk);
    check("drop_err_set", drop_err, 1);

    // Write during READ is dropped; flag stays set
    fork
      read_all("drop_in_read");
      begin
        repeat (8) tick();
        wr(2, 1'b1, splat(32'hDEAD_BEEF), 1'b1);
      end
    join
    check("drop_err_sticky", drop_err, 1);

    // Collision: write and readout request in the same idle cycle
    repeat (2) tick();
    vec = {$urandom, $urandom, $urandom, $urandom};
    for (int l = 0; l < RA; l++) model[7][l] = vec[l*OW +: OW];
    push_expected();
    deload_out = 1'b1; acc_first = 1'b1; addr_res = AW'(7); out_v = vec;
    test_en = 1'b1;
    tick();
    deload_out = 1'b0;
    @(negedge clk);
    check("coll_busy", busy, 1);
    check("coll_no_valid_yet", test_valid, 0);
    finish_read("collision");

    // Randomized writes with hot-row hazards and occasional out-of-range rows
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)      a = $urandom_range(16, 255);
      else if ($urandom_range(0, 1) == 1) a = 9;
      else                                a = $urandom_range(0, 15);
      vec = {$urandom, $urandom, $urandom, $urandom};
      wr(a, ($urandom_range(0, 3) == 0), vec, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    read_all("random");

    // Reset in the cycle after a write: row untouched, outputs cleared
    repeat (2) tick();
    deload_out = 1'b1; acc_first = 1'b1; addr_res = AW'(5); out_v = splat(32'h1234_5678);
    tick();
    deload_out = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstw_test_data", test_data, 0);
    check("rstw_test_valid", test_valid, 0);
    check("rstw_test_done", test_done, 0);
    check("rstw_busy", busy, 0);
    check("rstw_drop_err", drop_err, 0);
    read_all("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_drain_buffer.md
# result_drain_buffer

Downstream stage of the tiled systolic array top. It captures each row-wide result vector the array drains on `deload_out`. Per-tile partial sums are accumulated across the k-tile loop in an internal result RAM. On `test_en` the finished matrix is streamed out one lane per cycle on `test_data`.

## Interface
- `OUT_WIDTH`, 32: width of one result lane from the array.
- `ROW_A`, 4: lanes per drained row.
- `ADDR_WIDTH`, 8: width of `addr_res`.
- `DATA_WIDTH`, 32: readout width; must be ≤ `OUT_WIDTH`.
- `DEPTH`, 16: result rows stored; must be ≤ 2^`ADDR_WIDTH`.

- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `deload_out`, in, 1: `out`/`addr_res` valid this cycle.
- `acc_first`, in, 1: qualifies `deload_out`; 1 = first k-tile (overwrite), 0 = accumulate.
- `addr_res`, in, `ADDR_WIDTH`: destination row.
- `out`, in, `OUT_WIDTH*ROW_A`: drained row; lane i = bits [i*OUT_WIDTH +: OUT_WIDTH].
- `test_en`, in, 1: level request for serial readout.
- `test_data`, out, `DATA_WIDTH`: readout lane.
- `test_valid`, out, 1: `test_data` valid.
- `test_done`, out, 1: one-cycle pulse with the last lane.
- `busy`, out, 1: write pipeline non-empty or readout active.
- `drop_err`, out, 1: sticky; set on a dropped write.

## Operation
- FSM states:
  - IDLE → READ when `test_en`=1 and the write pipeline is empty.
  - READ → DONE after lane `DEPTH*ROW_A-1` is issued.
  - READ or DONE → IDLE when `test_en`=0.
  - DONE holds until `test_en`=0.
- Write path, 2-stage read-modify-write:
  - S1 registers addr, data and `acc_first`, and reads the RAM row.
  - S2 writes lane-wise. `acc_first`=1 writes `out`. `acc_first`=0 writes RAM+`out`.
  - Lane adds wrap modulo 2^`OUT_WIDTH`, with no carry between lanes.
- Hazard: if S1 addr equals S2 addr, the S2 write data is forwarded into the S1 read. Back-to-back accumulates to one row are exact.
- Dropped writes: `deload_out` with `addr_res` ≥ `DEPTH`, or in READ/DONE, is discarded and sets `drop_err`. `drop_err` is cleared only by `reset`.
- Readout:
  - A lane counter steps row-major: row 0 lane 0..`ROW_A-1`, then row 1, …
  - `test_data` = low `DATA_WIDTH` bits of the lane.
  - `test_en` deasserted mid-READ aborts. Counter returns to 0, no `test_done`, next READ restarts at lane 0.
- `deload_out` and `test_en` rising in the same IDLE cycle: the write wins. READ entry waits until the pipeline drains.
- Reset:
  - Clears FSM (IDLE), pipeline valids, counters, `drop_err`.
  - Aborts an in-flight write; a write in S2 during the reset cycle is not committed.
  - RAM contents are not cleared; `acc_first` defines row contents.
- Reset values: `test_data`=0, `test_valid`=0, `test_done`=0, `busy`=0, `drop_err`=0.

## Timing
- Write latency: `deload_out` in cycle N → RAM row updated at the edge ending cycle N+1. A read in cycle N+2 sees it.
- Throughput: one `deload_out` per cycle sustained; no backpressure.
- `busy`: high from the cycle after an accepted `deload_out` until S2 commits. It is also high throughout READ/DONE.
- Readout latency: `test_en` sampled high in IDLE at edge E (pipeline empty) → first `test_valid` in cycle E+2 (1-cycle RAM read).
- `test_valid` then stays high for `DEPTH*ROW_A` consecutive cycles. `test_done` is high with the final lane.
- On abort, `test_valid` drops the cycle after `test_en` is sampled low.

## Test plan
- Overwrite then readout: `DEPTH`=16, `ROW_A`=4. `deload_out`, `acc_first`=1 to rows 0..15 with lane value row*4+lane. `test_en`=1 → 64 valid lanes 0,1,…,63 starting 2 cycles after the sample edge; `test_done` with value 63.
- Accumulate back-to-back: row 3 `acc_first`=1 with lanes all 5, then the next cycle `acc_first`=0 with lanes 7, then again with 0xFFFFFFFF → readout row 3 lanes = 0x0000000B (wrap, forwarding exercised).
- Drop: `addr_res`=16 with `DEPTH`=16 → RAM unchanged, `drop_err`=1 the next cycle. `deload_out` during READ → dropped, `drop_err` stays 1 until `reset`.
- Abort/restart: `test_en` low after 10 valid lanes → `test_valid`=0 the next cycle, no `test_done`. Re-raise → stream restarts at lane 0 value 0.
- Collision: `deload_out` and `test_en` rise together → the write commits first, READ starts after `busy` falls, and the readout includes the new row.
- Reset mid-write: `reset` in the cycle after `deload_out` → the row is not modified, and all outputs are 0 the next cycle.
